reg_script_engine: RTL and testbench

//  Hardware register-access sequencer for on-target self-test. Runs a loaded script of WRITE,

---
 rtl/reg_script_engine.sv | 237 +++++++++++++++++++++++
 tb/tb_reg_script_engine.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_script_engine.sv
// Register-bus script sequencer: runs WRITE / CHECK / POLL / END entries over the byte-wide register bus.
// Optional SCRIPT_CAPTURE_EN keeps the most recent compared read word on last_rdata for debug.
module reg_script_engine #(
    parameter int pADDR_WIDTH   = 8,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pDATA_BYTES   = 4,
    parameter int pDEPTH        = 16,
    parameter int pPOLL_LIMIT   = 1024,
    parameter int pRD_LATENCY   = 1,
    localparam int IW = $clog2(pDEPTH),
    localparam int DW = 8 * pDATA_BYTES,
    localparam int EW = 2 + pADDR_WIDTH + 2 * DW
) (
    input  logic                     usb_clk,
    input  logic                     reset,
    input  logic                     ld_we,
    input  logic [IW-1:0]            ld_idx,
    input  logic [EW-1:0]            ld_entry,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [IW-1:0]            fail_idx,
    output logic [pADDR_WIDTH-1:0]   reg_address,
    output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    output logic                     reg_write,
    output logic                     reg_read,
    output logic [7:0]               reg_datao,
    input  logic [7:0]               reg_datai,
    output logic [DW-1:0]            last_rdata
);

    localparam int PW = $clog2(pPOLL_LIMIT + 1);
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_CHECK = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;
    localparam logic [IW-1:0]            LAST_IDX  = IW'(pDEPTH - 1);
    localparam logic [pBYTECNT_SIZE-1:0] LAST_BYTE = pBYTECNT_SIZE'(pDATA_BYTES - 1);
    localparam logic [1:0]               RD_LAT    = 2'(pRD_LATENCY);
    localparam logic [PW-1:0]            POLL_MAX  = PW'(pPOLL_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WR, S_RD, S_CMP, S_PWAIT, S_DONE
    } state_t;

    state_t                   state;
    logic [IW-1:0]            idx;
    logic [PW-1:0]            poll_cnt;
    logic [1:0]               wcnt;

    logic [EW-1:0]            script_mem [pDEPTH];
    logic [1:0]               cur_op;
    logic [DW-1:0]            cur_data;
    logic [DW-1:0]            cur_mask;
    logic [DW-1:0]            rdata;

    logic [EW-1:0]            fetch_entry;
    logic [1:0]               fetch_op;
    logic [pADDR_WIDTH-1:0]   fetch_addr;
    logic [DW-1:0]            fetch_data;
    logic [DW-1:0]            fetch_mask;
    logic [pBYTECNT_SIZE-1:0] nxt_b;
    logic [7:0]               nxt_wr_byte;
    logic [PW-1:0]            poll_cnt_nxt;
    logic                     rd_capture;
    logic                     last_entry;

    function automatic logic field_match(input logic [DW-1:0] rd,
                                         input logic [DW-1:0] exp,
                                         input logic [DW-1:0] msk);
        return ((rd ^ exp) & msk) == '0;
    endfunction

    assign fetch_entry  = script_mem[idx];
    assign fetch_op     = fetch_entry[EW-1 -: 2];
    assign fetch_addr   = fetch_entry[2*DW +: pADDR_WIDTH];
    assign fetch_data   = fetch_entry[DW +: DW];
    assign fetch_mask   = fetch_entry[0 +: DW];
    assign nxt_b        = reg_bytecnt + pBYTECNT_SIZE'(1);
    assign poll_cnt_nxt = poll_cnt + PW'(1);
    assign rd_capture   = (state == S_RD) && (wcnt == RD_LAT);
    assign last_entry   = (idx == LAST_IDX);

    always_comb begin
        nxt_wr_byte = '0;
        for (int k = 0; k < pDATA_BYTES; k++)
            if (nxt_b == pBYTECNT_SIZE'(k)) nxt_wr_byte = cur_data[8*k +: 8];
    end

    always_ff @(posedge usb_clk) begin
        if (ld_we && !busy) script_mem[ld_idx] <= ld_entry;
    end

    // Entry latch and read-byte assembly; data only, no reset needed
    always_ff @(posedge usb_clk) begin
        if (state == S_FETCH) begin
            cur_op   <= fetch_op;
            cur_data <= fetch_data;
            cur_mask <= fetch_mask;
        end
        for (int k = 0; k < pDATA_BYTES; k++)
            if (rd_capture && reg_bytecnt == pBYTECNT_SIZE'(k)) rdata[8*k +: 8] <= reg_datai;
    end

    always_ff @(posedge usb_clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            poll_cnt    <= '0;
            wcnt        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_idx    <= '0;
            reg_address <= '0;
            reg_bytecnt <= '0;
            reg_write   <= 1'b0;
            reg_read    <= 1'b0;
            reg_datao   <= '0;
        end else if (abort && busy) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b0;
            fail_idx  <= idx;
            reg_write <= 1'b0;
            reg_read  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (start && !abort) begin
                        state    <= S_FETCH;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        fail_idx <= '0;
                        idx      <= '0;
                    end
                end
                S_FETCH: begin
                    reg_address <= fetch_addr;
                    reg_bytecnt <= '0;
                    poll_cnt    <= '0;
                    wcnt        <= '0;
                    if (fetch_op == OP_WRITE) begin
                        state     <= S_WR;
                        reg_write <= 1'b1;
                        reg_datao <= fetch_data[7:0];
                    end else if (fetch_op == OP_CHECK || fetch_op == OP_POLL) begin
                        state    <= S_RD;
                        reg_read <= 1'b1;
                    end else begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end
                end
                S_WR: begin
                    if (reg_bytecnt == LAST_BYTE) begin
                        reg_write <= 1'b0;
                        if (last_entry) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= S_FETCH;
                        end
                    end else begin
                        reg_bytecnt <= nxt_b;
                        reg_datao   <= nxt_wr_byte;
                    end
                end
                S_RD: begin
                    // One read in flight: strobe, wait out the latency, capture, then next strobe
                    if (wcnt == 2'd0) begin
                        reg_read <= 1'b0;
                        wcnt     <= 2'd1;
                    end else if (wcnt == RD_LAT) begin
                        wcnt <= 2'd0;
                        if (reg_bytecnt == LAST_BYTE) begin
                            state <= S_CMP;
                        end else begin
                            reg_bytecnt <= nxt_b;
                            reg_read    <= 1'b1;
                        end
                    end else begin
                        wcnt <= wcnt + 2'd1;
                    end
                end
                S_CMP: begin
                    if (field_match(rdata, cur_data, cur_mask)) begin
                        if (last_entry) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= S_FETCH;
                        end
                    end else if (cur_op == OP_POLL && poll_cnt_nxt != POLL_MAX) begin
                        poll_cnt <= poll_cnt_nxt;
                        state    <= S_PWAIT;
                    end else begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        pass     <= 1'b0;
                        fail_idx <= idx;
                    end
                end
                S_PWAIT: begin
                    state       <= S_RD;
                    reg_read    <= 1'b1;
                    reg_bytecnt <= '0;
                    wcnt        <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SCRIPT_CAPTURE_EN
    always_ff @(posedge usb_clk or posedge reset) begin
        if (reset)                last_rdata <= '0;
        else if (state == S_CMP)  last_rdata <= rdata;
    end
`else
    assign last_rdata = '0;
`endif

endmodule

// File: tb/tb_reg_script_engine.sv
// Directed bench for reg_script_engine: default instance (a) and a POLL-limit-8, read-latency-3 instance (b).
module tb_reg_script_engine;
    localparam int IW = 4;
    localparam int DW = 32;
    localparam int EW = 2 + 8 + 2 * DW;
`ifdef SCRIPT_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic          usb_clk = 1'b0;
    logic          reset = 1'b1;
    logic          ld_we = 1'b0;
    logic [IW-1:0] ld_idx = '0;
    logic [EW-1:0] ld_entry = '0;
    logic          start_a = 1'b0, start_b = 1'b0, abort = 1'b0;

    logic busy_a, done_a, pass_a, reg_write_a, reg_read_a;
    logic [IW-1:0] fail_idx_a;
    logic [7:0] reg_address_a, reg_datao_a, reg_datai_a;
    logic [6:0] reg_bytecnt_a;
    logic [DW-1:0] last_rdata_a;
    logic busy_b, done_b, pass_b, reg_write_b, reg_read_b;
    logic [IW-1:0] fail_idx_b;
    logic [7:0] reg_address_b, reg_datao_b, reg_datai_b;
    logic [6:0] reg_bytecnt_b;
    logic [DW-1:0] last_rdata_b;

    int n_chk = 0, n_err = 0;

    // bus model controls: passes 1..switch return resp, later passes return resp2
    logic [31:0] resp_a = '0, resp2_a = '0, resp_b = '0, resp2_b = '0;
    int switch_a = 1000000, switch_b = 1000000;
    logic clr_cnt = 1'b0;
    int wr_cnt_a, rd_cnt_a, pass_cnt_a, wr_cnt_b, rd_cnt_b, pass_cnt_b;
    logic both_a, both_b;
    logic vld_a;
    logic [7:0] pa0;
    logic [2:0] vld_b;
    logic [7:0] pb0, pb1, pb2;

    reg_script_engine u_a (
        .usb_clk(usb_clk), .reset(reset), .ld_we(ld_we), .ld_idx(ld_idx), .ld_entry(ld_entry),
        .start(start_a), .abort(abort), .busy(busy_a), .done(done_a), .pass(pass_a),
        .fail_idx(fail_idx_a), .reg_address(reg_address_a), .reg_bytecnt(reg_bytecnt_a),
        .reg_write(reg_write_a), .reg_read(reg_read_a), .reg_datao(reg_datao_a),
        .reg_datai(reg_datai_a), .last_rdata(last_rdata_a));

    reg_script_engine #(.pPOLL_LIMIT(8), .pRD_LATENCY(3)) u_b (
        .usb_clk(usb_clk), .reset(reset), .ld_we(ld_we), .ld_idx(ld_idx), .ld_entry(ld_entry),
        .start(start_b), .abort(abort), .busy(busy_b), .done(done_b), .pass(pass_b),
        .fail_idx(fail_idx_b), .reg_address(reg_address_b), .reg_bytecnt(reg_bytecnt_b),
        .reg_write(reg_write_b), .reg_read(reg_read_b), .reg_datao(reg_datao_b),
        .reg_datai(reg_datai_b), .last_rdata(last_rdata_b));

    always #5 usb_clk = ~usb_clk;

    function automatic logic [7:0] pick(input logic [31:0] v, input logic [6:0] k);
        return 8'(v >> (8 * k));
    endfunction

    assign reg_datai_a = vld_a ? pa0 : 8'hEE;
    assign reg_datai_b = vld_b[2] ? pb2 : 8'hEE;

    always @(posedge usb_clk) begin
        if (clr_cnt) begin
            wr_cnt_a <= 0; rd_cnt_a <= 0; pass_cnt_a <= 0; both_a <= 1'b0;
        end else begin
            if (reg_write_a) wr_cnt_a <= wr_cnt_a + 1;
            if (reg_read_a) begin
                rd_cnt_a <= rd_cnt_a + 1;
                if (reg_bytecnt_a == 7'd0) pass_cnt_a <= pass_cnt_a + 1;
            end
            if (reg_write_a && reg_read_a) both_a <= 1'b1;
        end
        vld_a <= reg_read_a;
        pa0   <= pick(((pass_cnt_a + int'(reg_bytecnt_a == 7'd0)) <= switch_a) ? resp_a : resp2_a,
                      reg_bytecnt_a);
    end

    always @(posedge usb_clk) begin
        if (clr_cnt) begin
            wr_cnt_b <= 0; rd_cnt_b <= 0; pass_cnt_b <= 0; both_b <= 1'b0;
        end else begin
            if (reg_write_b) wr_cnt_b <= wr_cnt_b + 1;
            if (reg_read_b) begin
                rd_cnt_b <= rd_cnt_b + 1;
                if (reg_bytecnt_b == 7'd0) pass_cnt_b <= pass_cnt_b + 1;
            end
            if (reg_write_b && reg_read_b) both_b <= 1'b1;
        end
        vld_b <= {vld_b[1:0], reg_read_b};
        pb0   <= pick(((pass_cnt_b + int'(reg_bytecnt_b == 7'd0)) <= switch_b) ? resp_b : resp2_b,
                      reg_bytecnt_b);
        pb1   <= pb0;
        pb2   <= pb1;
    end

    task automatic tick();
        @(posedge usb_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int i, input logic [1:0] op, input logic [7:0] a,
                        input logic [31:0] d, input logic [31:0] m);
        ld_idx   = IW'(i);
        ld_entry = {op, a, d, m};
        ld_we    = 1'b1;
        tick();
        ld_we    = 1'b0;
    endtask

    task automatic clear_counts();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
    endtask

    task automatic wait_done(input bit use_b, input int bound, input string tag);
        int n = 0;
        while (!(use_b ? done_b : done_a) && n < bound) begin
            tick();
            n++;
        end
        chk(tag, 64'(use_b ? done_b : done_a), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        chk("rst_busy", 64'(busy_a), 0);
        chk("rst_done", 64'(done_a), 0);
        chk("rst_pass", 64'(pass_b), 0);
        chk("rst_wr", 64'(reg_write_a), 0);
        chk("rst_rd", 64'(reg_read_b), 0);
        chk("rst_addr", 64'(reg_address_a), 0);
        chk("rst_last", 64'(last_rdata_a), 0);
        reset = 1'b0;
        tick();

        // 1: WRITE 0x20 = 0x00000003 then END
        load(0, 2'b00, 8'h20, 32'h0000_0003, 32'h0);
        load(1, 2'b11, 8'h00, 32'h0, 32'h0);
        clear_counts();
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("s1_busy", 64'(busy_a), 1);
        chk("s1_fetch_wr", 64'(reg_write_a), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("s1_wr", 64'(reg_write_a), 1);
            chk("s1_bcnt", 64'(reg_bytecnt_a), 64'(k));
            chk("s1_dato", 64'(reg_datao_a), (k == 0) ? 64'h03 : 64'h00);
            chk("s1_addr", 64'(reg_address_a), 64'h20);
        end
        tick();
        chk("s1_wr_end", 64'(reg_write_a), 0);
        chk("s1_not_done", 64'(done_a), 0);
        tick();
        chk("s1_done", 64'(done_a), 1);
        chk("s1_pass", 64'(pass_a), 1);
        chk("s1_idle", 64'(busy_a), 0);
        chk("s1_wrcnt", 64'(wr_cnt_a), 4);
        chk("s1_rdcnt", 64'(rd_cnt_a), 0);

        // 2: CHECK 0x30 against 0x8a278bf8, exact strobe spacing at latency 1
        load(0, 2'b01, 8'h30, 32'h8a27_8bf8, 32'hffff_ffff);
        resp_a = 32'h8a27_8bf8; switch_a = 1000000;
        clear_counts();
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("s2_done_clr", 64'(done_a), 0);
        tick();
        chk("s2_rd0", 64'(reg_read_a), 1);
        chk("s2_bc0", 64'(reg_bytecnt_a), 0);
        chk("s2_addr", 64'(reg_address_a), 64'h30);
        tick();
        chk("s2_rdgap", 64'(reg_read_a), 0);
        tick();
        chk("s2_rd1", 64'(reg_read_a), 1);
        chk("s2_bc1", 64'(reg_bytecnt_a), 1);
        wait_done(1'b0, 100, "s2_wait");
        chk("s2_pass", 64'(pass_a), 1);
        chk("s2_rdcnt", 64'(rd_cnt_a), 4);
        chk("s2_last", 64'(last_rdata_a), CAP ? 64'h8a27_8bf8 : 64'h0);
        resp_a = 32'h8a27_8bf9;
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_done(1'b0, 100, "s2b_wait");
        chk("s2b_pass", 64'(pass_a), 0);
        chk("s2b_fidx", 64'(fail_idx_a), 0);
        chk("s2b_last", 64'(last_rdata_a), CAP ? 64'h8a27_8bf9 : 64'h0);

        // 3: POLL bit0 of 0x05 until clear: reads 1,1,1,0
        load(0, 2'b10, 8'h05, 32'h0, 32'h0000_0001);
        resp_a = 32'h1; resp2_a = 32'h0; switch_a = 3;
        clear_counts();
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_done(1'b0, 300, "s3_wait");
        chk("s3_pass", 64'(pass_a), 1);
        chk("s3_passes", 64'(pass_cnt_a), 4);
        chk("s3_rdcnt", 64'(rd_cnt_a), 16);
        chk("s3_excl", 64'(both_a), 0);

        // 4: POLL stuck at 1 on the limit-8 instance; a mid-run start must not restart it
        resp_b = 32'h1; switch_b = 1000000;
        clear_counts();
        start_b = 1'b1; tick(); start_b = 1'b0;
        repeat (20) tick();
        start_b = 1'b1; tick(); start_b = 1'b0;
        chk("s4_busy", 64'(busy_b), 1);
        wait_done(1'b1, 600, "s4_wait");
        chk("s4_pass", 64'(pass_b), 0);
        chk("s4_fidx", 64'(fail_idx_b), 0);
        chk("s4_passes", 64'(pass_cnt_b), 8);
        chk("s4_rdcnt", 64'(rd_cnt_b), 32);
        chk("s4_excl", 64'(both_b), 0);

        // 5: abort after the second write byte, then abort inside entry 1
        load(0, 2'b00, 8'h20, 32'h4433_2211, 32'h0);
        load(1, 2'b00, 8'h21, 32'h8877_6655, 32'h0);
        load(2, 2'b11, 8'h00, 32'h0, 32'h0);
        clear_counts();
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick();
        chk("s5_b0", 64'(reg_datao_a), 64'h11);
        tick();
        chk("s5_b1", 64'(reg_datao_a), 64'h22);
        chk("s5_bc1", 64'(reg_bytecnt_a), 1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("s5_wr_off", 64'(reg_write_a), 0);
        chk("s5_done", 64'(done_a), 1);
        chk("s5_pass", 64'(pass_a), 0);
        chk("s5_busy", 64'(busy_a), 0);
        chk("s5_fidx", 64'(fail_idx_a), 0);
        repeat (5) tick();
        chk("s5_wrcnt", 64'(wr_cnt_a), 2);
        chk("s5_hold", 64'(done_a), 1);
        start_a = 1'b1; tick(); start_a = 1'b0;
        repeat (6) tick();
        chk("s5b_addr", 64'(reg_address_a), 64'h21);
        chk("s5b_dato", 64'(reg_datao_a), 64'h55);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("s5b_done", 64'(done_a), 1);
        chk("s5b_fidx", 64'(fail_idx_a), 1);
        chk("s5b_pass", 64'(pass_a), 0);

        // 6: latency-3 CHECK timing, then asynchronous reset in the middle of a read
        load(0, 2'b01, 8'h30, 32'ha1b2_c3d4, 32'hffff_ffff);
        load(1, 2'b11, 8'h00, 32'h0, 32'h0);
        resp_b = 32'ha1b2_c3d4;
        start_b = 1'b1; tick(); start_b = 1'b0;
        tick();
        chk("s6_rd0", 64'(reg_read_b), 1);
        repeat (3) begin
            tick();
            chk("s6_gap", 64'(reg_read_b), 0);
        end
        tick();
        chk("s6_rd1", 64'(reg_read_b), 1);
        chk("s6_bc1", 64'(reg_bytecnt_b), 1);
        wait_done(1'b1, 100, "s6_wait");
        chk("s6_pass", 64'(pass_b), 1);
        chk("s6_last", 64'(last_rdata_b), CAP ? 64'ha1b2_c3d4 : 64'h0);
        start_b = 1'b1; tick(); start_b = 1'b0;
        repeat (5) tick();
        chk("s6_mid_rd", 64'(reg_read_b), 1);
        #2 reset = 1'b1;
        #1;
        chk("s6r_rd", 64'(reg_read_b), 0);
        chk("s6r_bc", 64'(reg_bytecnt_b), 0);
        chk("s6r_addr", 64'(reg_address_b), 0);
        chk("s6r_busy", 64'(busy_b), 0);
        chk("s6r_last", 64'(last_rdata_b), 0);
        chk("s6r_done_a", 64'(done_a), 0);
        #3 reset = 1'b0;
        tick();
        chk("s6r_idle", 64'(busy_b), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
